// File: rtl/affine_prog_loader.sv
// Program loader for the affine PicoMIPS core: unpacks a framed byte stream into
// 26-bit instruction words, writes them to program memory and verifies a trailing XOR checksum.
module affine_prog_loader #(
  parameter int W_INST = 26,
  parameter int PA     = 5
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              prog_we,
  output logic [PA-1:0]     prog_addr,
  output logic [W_INST-1:0] prog_wdata,
  output logic              core_run,
  output logic              load_err,
  output logic [PA:0]       word_count
);

  typedef enum logic [2:0] {S_HDR, S_BYTE, S_WR, S_CSUM, S_RUN, S_ERR} state_t;

  localparam logic [8:0] MAX_LEN  = 9'(2 ** PA);
  localparam logic [PA:0] ONE_CNT = (PA + 1)'(1);

  state_t              state, state_nxt;
  logic [PA:0]         len_q;
  logic [PA:0]         word_cnt;
  logic [1:0]          byte_idx;
  logic [W_INST-1:0]   asm_q;
  logic [7:0]          csum;
  logic                accept;
  logic                hdr_bad;
  logic                top_bad;
  logic                last_word;

  assign accept    = rx_valid && rx_ready;
  assign hdr_bad   = (rx_data == 8'd0) || ({1'b0, rx_data} > MAX_LEN);
  assign top_bad   = (byte_idx == 2'd0) && (rx_data[7:2] != 6'd0);
  assign last_word = ((word_cnt + ONE_CNT) == len_q);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= S_HDR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    prog_we   = 1'b0;
    core_run  = 1'b0;
    load_err  = 1'b0;
    case (state)
      S_HDR: begin
        rx_ready = 1'b1;
        if (accept) state_nxt = hdr_bad ? S_ERR : S_BYTE;
      end
      S_BYTE: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (top_bad)                  state_nxt = S_ERR;
          else if (byte_idx == 2'd3)    state_nxt = S_WR;
        end
      end
      S_WR: begin
        prog_we   = 1'b1;
        state_nxt = last_word ? S_CSUM : S_BYTE;
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        if (accept) state_nxt = (rx_data == csum) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        core_run = 1'b1;
        if (reload) state_nxt = S_HDR;
      end
      S_ERR: begin
        load_err = 1'b1;
        if (reload) state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
  end

  // Assembly register doubles as the write-data register: it is frozen during S_WR.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      len_q    <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      csum     <= '0;
    end else begin
      case (state)
        S_HDR: begin
          if (accept && !hdr_bad) begin
            len_q    <= rx_data[PA:0];
            csum     <= rx_data;
            word_cnt <= '0;
            byte_idx <= '0;
          end
        end
        S_BYTE: begin
          if (accept) begin
            asm_q    <= {asm_q[W_INST-9:0], rx_data};
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WR: word_cnt <= word_cnt + ONE_CNT;
        S_RUN, S_ERR: begin
          if (reload) begin
            csum     <= '0;
            word_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign prog_addr  = word_cnt[PA-1:0];
  assign prog_wdata = asm_q;
  assign word_count = word_cnt;

endmodule

// File: tb/tb_affine_prog_loader.sv
// Directed testbench for affine_prog_loader: frames are pushed byte by byte and
// outputs are compared against hand-computed values and a small checksum model.
module tb_affine_prog_loader;

  localparam int PA     = 5;
  localparam int W_INST = 26;

  logic              clk = 1'b0;
  logic              nReset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              reload = 1'b0;
  logic              prog_we;
  logic [PA-1:0]     prog_addr;
  logic [W_INST-1:0] prog_wdata;
  logic              core_run;
  logic              load_err;
  logic [PA:0]       word_count;

  int checks = 0;
  int failures = 0;

  int               we_cnt = 0;
  int               ready_viol = 0;
  logic             prev_we = 1'b0;
  logic [PA-1:0]    wr_addr [64];
  logic [25:0]      wr_data [64];

  affine_prog_loader #(.W_INST(W_INST), .PA(PA)) dut (
    .clk(clk), .nReset(nReset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .core_run(core_run), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Write log plus a watch on rx_ready being low exactly when writing, running or errored.
  always @(negedge clk) begin
    if (prog_we) begin
      if (we_cnt < 64) begin
        wr_addr[we_cnt] = prog_addr;
        wr_data[we_cnt] = prog_wdata;
      end
      we_cnt++;
    end
    if (nReset && (rx_ready !== !(prog_we || core_run || load_err))) ready_viol++;
    if (prog_we && prev_we) ready_viol++;
    prev_we = prog_we;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      if (rx_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("[TB] FAIL accept_timeout got=stalled exp=accepted byte=%0h", b);
    end
  endtask

  task automatic sendWord(input logic [25:0] w);
    applyStimulus({6'd0, w[25:24]});
    applyStimulus(w[23:16]);
    applyStimulus(w[15:8]);
    applyStimulus(w[7:0]);
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulseReload();
    @(negedge clk);
    rx_valid = 1'b0;
    reload   = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(rx_ready), 32'd1);
    checkOutput({tag, "_we"},    32'(prog_we), 32'd0);
    checkOutput({tag, "_addr"},  32'(prog_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(prog_wdata), 32'd0);
    checkOutput({tag, "_run"},   32'(core_run), 32'd0);
    checkOutput({tag, "_err"},   32'(load_err), 32'd0);
    checkOutput({tag, "_wcnt"},  32'(word_count), 32'd0);
  endtask

  logic [25:0] prog_words [32];
  logic [7:0]  model_csum;
  int          base;

  initial begin
    // Reset state
    #2 nReset = 1'b0;
    #10;
    checkResetValues("reset");
    @(negedge clk);
    nReset = 1'b1;

    // Single word frame with good checksum
    base = we_cnt;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    checkOutput("single_we", 32'(prog_we), 32'd1);
    checkOutput("single_addr", 32'(prog_addr), 32'd0);
    checkOutput("single_wdata", 32'(prog_wdata), 32'h2123456);
    checkOutput("single_ready_in_wr", 32'(rx_ready), 32'd0);
    applyStimulus(8'h73);
    checkOutput("single_run", 32'(core_run), 32'd1);
    checkOutput("single_err", 32'(load_err), 32'd0);
    checkOutput("single_wcnt", 32'(word_count), 32'd1);
    idle();
    checkOutput("single_writes", 32'(we_cnt - base), 32'd1);
    checkOutput("single_log_data", 32'(wr_data[base]), 32'h2123456);

    pulseReload();
    checkOutput("reload_run_drop", 32'(core_run), 32'd0);
    checkOutput("reload_ready", 32'(rx_ready), 32'd1);
    checkOutput("reload_wcnt", 32'(word_count), 32'd0);

    // Bad checksum
    base = we_cnt;
    applyStimulus(8'h01);
    sendWord(26'h2123456);
    applyStimulus(8'h74);
    checkOutput("badcs_err", 32'(load_err), 32'd1);
    checkOutput("badcs_run", 32'(core_run), 32'd0);
    idle();
    checkOutput("badcs_writes", 32'(we_cnt - base), 32'd1);
    checkOutput("badcs_log_addr", 32'(wr_addr[base]), 32'd0);
    pulseReload();
    checkOutput("badcs_reload_err", 32'(load_err), 32'd0);
    checkOutput("badcs_reload_ready", 32'(rx_ready), 32'd1);

    // Illegal headers
    base = we_cnt;
    applyStimulus(8'h00);
    checkOutput("hdr0_err", 32'(load_err), 32'd1);
    pulseReload();
    applyStimulus(8'h21);
    checkOutput("hdr21_err", 32'(load_err), 32'd1);
    idle();
    checkOutput("hdr_writes", 32'(we_cnt - base), 32'd0);
    pulseReload();

    // Illegal top byte of an instruction word
    base = we_cnt;
    applyStimulus(8'h02);
    applyStimulus(8'h04);
    checkOutput("topbyte_err", 32'(load_err), 32'd1);
    idle();
    checkOutput("topbyte_writes", 32'(we_cnt - base), 32'd0);
    pulseReload();

    // Full 32-word program with valid held high throughout
    base = we_cnt;
    model_csum = 8'h20;
    for (int i = 0; i < 32; i++) begin
      prog_words[i] = 26'($urandom());
      model_csum ^= {6'd0, prog_words[i][25:24]} ^ prog_words[i][23:16]
                    ^ prog_words[i][15:8] ^ prog_words[i][7:0];
    end
    applyStimulus(8'h20);
    for (int i = 0; i < 32; i++) sendWord(prog_words[i]);
    applyStimulus(model_csum);
    checkOutput("full_run", 32'(core_run), 32'd1);
    checkOutput("full_wcnt", 32'(word_count), 32'd32);
    idle();
    checkOutput("full_writes", 32'(we_cnt - base), 32'd32);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("full_addr%0d", i), 32'(wr_addr[base + i]), 32'(i));
      checkOutput($sformatf("full_data%0d", i), 32'(wr_data[base + i]), 32'(prog_words[i]));
    end
    checkOutput("ready_protocol", 32'(ready_viol), 32'd0);
    pulseReload();

    // Reset in the middle of the second word
    applyStimulus(8'h02);
    sendWord(26'h1ABCDEF);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    idle();
    base = we_cnt;
    #1 nReset = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midreset_writes", 32'(we_cnt - base), 32'd0);
    @(negedge clk);
    nReset = 1'b1;

    // Fresh frame after reset; a reload pulse mid-word must be ignored
    base = we_cnt;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    pulseReload();
    checkOutput("reload_ignored_ready", 32'(rx_ready), 32'd1);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h73);
    checkOutput("fresh_run", 32'(core_run), 32'd1);
    checkOutput("fresh_wcnt", 32'(word_count), 32'd1);
    idle();
    checkOutput("fresh_writes", 32'(we_cnt - base), 32'd1);
    checkOutput("fresh_data", 32'(wr_data[base]), 32'h2123456);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
